// File: rtl/legv8_bus_bridge_if.sv
// Signal bundle between the LEGv8 bus bridge, the CPU core and the external
// memory/IO bus.
//   master : the bridge's view (takes CPU requests, drives the bus beats)
//   slave  : the environment's view (CPU core plus bus target)
interface legv8_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BUS_WIDTH  = 16
);

  // CPU side
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;
  logic                  cpu_done;
  logic                  cpu_err;

  // external bus side
  logic                  bus_valid;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [BUS_WIDTH-1:0]  bus_wdata;
  logic [BUS_WIDTH-1:0]  bus_rdata;
  logic                  bus_ready;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall, cpu_done, cpu_err,
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall, cpu_done, cpu_err,
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );

endinterface

// File: rtl/legv8_bus_bridge.sv
// LEGv8 memory-bus bridge: splits each DATA_WIDTH CPU access into
// BEATS = DATA_WIDTH/BUS_WIDTH sequential valid/ready beats on a narrower
// bus, stalling the CPU until the access completes.
// Optional feature macro: LEGV8_BUS_TIMEOUT_EN -- per-beat wait counter that
// aborts a stuck beat after TIMEOUT wait cycles and reports cpu_err.
// All bus-side outputs and the CPU completion flags are registered; only
// cpu_stall is combinational so the CPU freezes in the request cycle.
module legv8_bus_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BUS_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  legv8_bus_bridge_if.master    bif
);

  localparam int BEATS  = DATA_WIDTH / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTES  = BUS_WIDTH / 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // reject configurations the beat slicing cannot represent
  if (((DATA_WIDTH % BUS_WIDTH) != 0) || ((BUS_WIDTH % 8) != 0) ||
      (BEATS < 1) || (BEATS > 8) || (TIMEOUT < 1)) begin : g_bad_cfg
    $error("legv8_bus_bridge: illegal parameter configuration");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r,      state_next_s;
  logic [BEAT_W-1:0]       beat_r,       beat_next_s;
  logic [ADDR_WIDTH-1:0]   base_r,       base_next_s;
  logic                    we_r,         we_next_s;
  logic [DATA_WIDTH-1:0]   wdata_r,      wdata_next_s;
  logic [DATA_WIDTH-1:0]   asm_r,        asm_next_s;
  logic [DATA_WIDTH-1:0]   rdata_r,      rdata_next_s;
  logic                    done_r,       done_next_s;
  logic                    err_r,        err_next_s;
  logic                    bus_valid_r,  bus_valid_next_s;
  logic                    bus_we_r,     bus_we_next_s;
  logic [ADDR_WIDTH-1:0]   bus_addr_r,   bus_addr_next_s;
  logic [BUS_WIDTH-1:0]    bus_wdata_r,  bus_wdata_next_s;

`ifdef LEGV8_BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  // the abort fires on the wait cycle that would bring the count to TIMEOUT
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0]       wait_cnt_r,   wait_cnt_next_s;
`endif

  // state register plus all registered outputs, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      beat_r      <= '0;
      base_r      <= '0;
      we_r        <= 1'b0;
      wdata_r     <= '0;
      asm_r       <= '0;
      rdata_r     <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      bus_valid_r <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
`ifdef LEGV8_BUS_TIMEOUT_EN
      wait_cnt_r  <= '0;
`endif
    end else begin
      state_r     <= state_next_s;
      beat_r      <= beat_next_s;
      base_r      <= base_next_s;
      we_r        <= we_next_s;
      wdata_r     <= wdata_next_s;
      asm_r       <= asm_next_s;
      rdata_r     <= rdata_next_s;
      done_r      <= done_next_s;
      err_r       <= err_next_s;
      bus_valid_r <= bus_valid_next_s;
      bus_we_r    <= bus_we_next_s;
      bus_addr_r  <= bus_addr_next_s;
      bus_wdata_r <= bus_wdata_next_s;
`ifdef LEGV8_BUS_TIMEOUT_EN
      wait_cnt_r  <= wait_cnt_next_s;
`endif
    end
  end

  // next-state, request latching, read assembly and next registered outputs
  always_comb begin
    state_next_s     = state_r;
    beat_next_s      = beat_r;
    base_next_s      = base_r;
    we_next_s        = we_r;
    wdata_next_s     = wdata_r;
    asm_next_s       = asm_r;
    rdata_next_s     = rdata_r;
    done_next_s      = 1'b0;
    err_next_s       = 1'b0;
    bus_valid_next_s = 1'b0;
    bus_we_next_s    = 1'b0;
    bus_addr_next_s  = bus_addr_r;
    bus_wdata_next_s = bus_wdata_r;
`ifdef LEGV8_BUS_TIMEOUT_EN
    wait_cnt_next_s  = wait_cnt_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (bif.cpu_req) begin
          // the whole request is captured here; later cpu_* changes are ignored
          base_next_s  = bif.cpu_addr;
          we_next_s    = bif.cpu_we;
          wdata_next_s = bif.cpu_wdata;
          beat_next_s  = '0;
          state_next_s = ST_BEAT;
`ifdef LEGV8_BUS_TIMEOUT_EN
          wait_cnt_next_s = '0;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_BEAT: begin
        if (bif.bus_ready) begin
          if (!we_r) begin
            asm_next_s[int'(beat_r) * BUS_WIDTH +: BUS_WIDTH] = bif.bus_rdata;
          end else begin
            asm_next_s = asm_r;
          end
`ifdef LEGV8_BUS_TIMEOUT_EN
          wait_cnt_next_s = '0;
`endif
          if (beat_r == LAST_BEAT) begin
            state_next_s = ST_DONE;
            done_next_s  = 1'b1;
            // read data is presented together with the done pulse
            if (!we_r) begin
              rdata_next_s = asm_next_s;
            end else begin
              rdata_next_s = rdata_r;
            end
          end else begin
            beat_next_s  = beat_r + 1'b1;
            state_next_s = ST_BEAT;
          end
        end else begin
`ifdef LEGV8_BUS_TIMEOUT_EN
          if (wait_cnt_r >= WAIT_LIMIT) begin
            // stuck beat: abandon the remaining beats and flag the error
            state_next_s = ST_DONE;
            done_next_s  = 1'b1;
            err_next_s   = 1'b1;
            if (!we_r) begin
              rdata_next_s = '1;
            end else begin
              rdata_next_s = rdata_r;
            end
          end else begin
            wait_cnt_next_s = wait_cnt_r + 1'b1;
            state_next_s    = ST_BEAT;
          end
`else
          state_next_s = ST_BEAT;
`endif
        end
      end

      ST_DONE: begin
        // a request seen here is ignored; it is taken up again in IDLE
        state_next_s = ST_IDLE;
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // beat outputs follow the beat that will be active after this edge
    if (state_next_s == ST_BEAT) begin
      bus_valid_next_s = 1'b1;
      bus_we_next_s    = we_next_s;
      bus_addr_next_s  = base_next_s +
                         (ADDR_WIDTH'(beat_next_s) * ADDR_WIDTH'(BYTES));
      bus_wdata_next_s = wdata_next_s[int'(beat_next_s) * BUS_WIDTH +: BUS_WIDTH];
    end else begin
      bus_valid_next_s = 1'b0;
      bus_we_next_s    = 1'b0;
      bus_addr_next_s  = bus_addr_r;
      bus_wdata_next_s = bus_wdata_r;
    end
  end

  assign bif.cpu_stall = (state_r == ST_BEAT) | ((state_r == ST_IDLE) & bif.cpu_req);
  assign bif.cpu_rdata = rdata_r;
  assign bif.cpu_done  = done_r;
  assign bif.cpu_err   = err_r;
  assign bif.bus_valid = bus_valid_r;
  assign bif.bus_we    = bus_we_r;
  assign bif.bus_addr  = bus_addr_r;
  assign bif.bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_legv8_bus_bridge.sv
// Self-checking bench for legv8_bus_bridge (default widths: 64-bit CPU word,
// 16-bit bus, 4 beats). Directed transactions come from a table; random
// transactions are checked against a transaction-level reference model.
module tb_legv8_bus_bridge;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 16;
  localparam int NB = 4;

  logic clock;
  logic reset;

  legv8_bus_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUS_WIDTH(BW)) bif ();

  legv8_bus_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUS_WIDTH(BW), .TIMEOUT(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bif   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic                 we;
    logic [AW-1:0]        addr;
    logic [DW-1:0]        wdata;
    logic [NB-1:0][BW-1:0] rbeat;
    logic [NB-1:0][1:0]   waits;
    logic [NB-1:0][AW-1:0] exp_addr;
    logic [NB-1:0][BW-1:0] exp_wdata;
    int                   exp_lat;
    logic [DW-1:0]        exp_rdata;
  } txn_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_rdata = '0;
  txn_t tbl [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference model: expected beats and result from the access rules alone
  function automatic txn_t make_random();
    txn_t t;
    int total;
    t.we    = 1'($urandom_range(1, 0));
    t.addr  = $urandom;
    if ($urandom_range(3, 0) == 0) t.addr = 32'hFFFF_FFF8 + 32'($urandom_range(7, 0));
    t.wdata = {$urandom, $urandom};
    t.rbeat = {$urandom, $urandom};
    total = 0;
    for (int k = 0; k < NB; k++) begin
      t.waits[k]     = 2'($urandom_range(2, 0));
      total         += int'(t.waits[k]);
      t.exp_addr[k]  = t.addr + 32'(2 * k);
      t.exp_wdata[k] = 16'(t.wdata >> (16 * k));
    end
    t.exp_lat   = 1 + NB + total;
    t.exp_rdata = t.we ? model_rdata : 64'(t.rbeat);
    return t;
  endfunction

  // one complete CPU access, acting as both CPU and bus target
  task automatic do_access(input txn_t t, input bit scramble);
    int  k;
    int  wl;
    bit  seen;
    k    = 0;
    seen = 1'b0;
    wl   = int'(t.waits[0]);
    @(negedge clock);
    bif.cpu_req   = 1'b1;
    bif.cpu_we    = t.we;
    bif.cpu_addr  = t.addr;
    bif.cpu_wdata = t.wdata;
    bif.bus_ready = 1'($urandom_range(1, 0));
    bif.bus_rdata = 16'($urandom);
    #1;
    check("stall_req", 64'(bif.cpu_stall), 64'd1);
    check("valid_idle", 64'(bif.bus_valid), 64'd0);
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clock);
      if (scramble) begin
        bif.cpu_req   = 1'($urandom_range(1, 0));
        bif.cpu_we    = 1'($urandom_range(1, 0));
        bif.cpu_addr  = $urandom;
        bif.cpu_wdata = {$urandom, $urandom};
      end else begin
        bif.cpu_req   = 1'b0;
      end
      if (bif.bus_valid) begin
        if (k >= NB) begin
          check("beat_overrun", 64'(k), 64'(NB - 1));
          bif.bus_ready = 1'b1;
        end else begin
          check("bus_addr", 64'(bif.bus_addr), 64'(t.exp_addr[k]));
          check("bus_we", 64'(bif.bus_we), 64'(t.we));
          if (t.we) check("bus_wdata", 64'(bif.bus_wdata), 64'(t.exp_wdata[k]));
          if (wl > 0) begin
            bif.bus_ready = 1'b0;
            bif.bus_rdata = 16'($urandom);
            wl--;
          end else begin
            bif.bus_ready = 1'b1;
            bif.bus_rdata = t.rbeat[k];
            k++;
            if (k < NB) wl = int'(t.waits[k]);
          end
        end
      end else begin
        bif.bus_ready = 1'($urandom_range(1, 0));
        bif.bus_rdata = 16'($urandom);
      end
      #1;
      if (bif.cpu_done) begin
        seen = 1'b1;
        check("latency", 64'(c), 64'(t.exp_lat));
        check("beats_done", 64'(k), 64'(NB));
        check("err_ok", 64'(bif.cpu_err), 64'd0);
        check("valid_done", 64'(bif.bus_valid), 64'd0);
        check("stall_done", 64'(bif.cpu_stall), 64'd0);
      end else begin
        check("stall_busy", 64'(bif.cpu_stall), 64'd1);
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    @(negedge clock);
    bif.cpu_req   = 1'b0;
    bif.bus_ready = 1'b0;
    #1;
    check("cpu_rdata", bif.cpu_rdata, t.exp_rdata);
    check("done_once", 64'(bif.cpu_done), 64'd0);
    check("stall_idle", 64'(bif.cpu_stall), 64'd0);
    model_rdata = t.exp_rdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int npulse;
    logic [AW-1:0] exp_base;

    tbl[0] = '{we: 1'b0, addr: 32'h0000_0100, wdata: 64'h0,
               rbeat: {16'h4444, 16'h3333, 16'h2222, 16'h1111}, waits: 8'h00,
               exp_addr: {32'h106, 32'h104, 32'h102, 32'h100},
               exp_wdata: 64'h0, exp_lat: 5, exp_rdata: 64'h4444_3333_2222_1111};
    tbl[1] = '{we: 1'b1, addr: 32'h0000_0300, wdata: 64'hDEAD_BEEF_CAFE_F00D,
               rbeat: 64'h0, waits: {2'd0, 2'd0, 2'd2, 2'd0},
               exp_addr: {32'h306, 32'h304, 32'h302, 32'h300},
               exp_wdata: {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D},
               exp_lat: 7, exp_rdata: 64'h4444_3333_2222_1111};
    tbl[2] = '{we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 64'h0,
               rbeat: {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, waits: 8'h00,
               exp_addr: {32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFC},
               exp_wdata: 64'h0, exp_lat: 5, exp_rdata: 64'hDDDD_CCCC_BBBB_AAAA};
    tbl[3] = '{we: 1'b0, addr: 32'h0000_1000, wdata: 64'h0,
               rbeat: {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123},
               waits: {2'd3, 2'd0, 2'd0, 2'd1},
               exp_addr: {32'h1006, 32'h1004, 32'h1002, 32'h1000},
               exp_wdata: 64'h0, exp_lat: 9, exp_rdata: 64'hCDEF_89AB_4567_0123};

    reset         = 1'b0;
    bif.cpu_req   = 1'b0;
    bif.cpu_we    = 1'b0;
    bif.cpu_addr  = '0;
    bif.cpu_wdata = '0;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_valid", 64'(bif.bus_valid), 64'd0);
    check("rst_we", 64'(bif.bus_we), 64'd0);
    check("rst_addr", 64'(bif.bus_addr), 64'd0);
    check("rst_wdata", 64'(bif.bus_wdata), 64'd0);
    check("rst_rdata", bif.cpu_rdata, 64'd0);
    check("rst_done", 64'(bif.cpu_done), 64'd0);
    check("rst_err", 64'(bif.cpu_err), 64'd0);
    check("rst_stall", 64'(bif.cpu_stall), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // directed transactions from the table
    for (int i = 0; i < 4; i++) do_access(tbl[i], 1'b0);

    // reset during beat 2 of a read abandons it without a done pulse
    @(negedge clock);
    bif.cpu_req  = 1'b1;
    bif.cpu_we   = 1'b0;
    bif.cpu_addr = 32'h0000_0400;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      bif.cpu_req   = 1'b0;
      bif.bus_ready = 1'b1;
      bif.bus_rdata = 16'h9999;
    end
    @(negedge clock);
    check("mid_addr", 64'(bif.bus_addr), 64'h404);
    reset = 1'b0;
    #1;
    check("mid_valid", 64'(bif.bus_valid), 64'd0);
    check("mid_done", 64'(bif.cpu_done), 64'd0);
    check("mid_baddr", 64'(bif.bus_addr), 64'd0);
    check("mid_rdata", bif.cpu_rdata, 64'd0);
    bif.bus_ready = 1'b0;
    repeat (2) begin
      @(negedge clock);
      #1;
      check("mid_nodone", 64'(bif.cpu_done), 64'd0);
    end
    reset = 1'b1;
    model_rdata = '0;
    begin
      txn_t t;
      t = '{we: 1'b0, addr: 32'h0000_0200, wdata: 64'h0,
            rbeat: {16'h8888, 16'h7777, 16'h6666, 16'h5555}, waits: 8'h00,
            exp_addr: {32'h206, 32'h204, 32'h202, 32'h200},
            exp_wdata: 64'h0, exp_lat: 5, exp_rdata: 64'h8888_7777_6666_5555};
      do_access(t, 1'b0);
    end

    // cpu_req held high: done pulses BEATS+2 apart, address re-latched each time
    @(negedge clock);
    bif.cpu_req  = 1'b1;
    bif.cpu_we   = 1'b0;
    bif.cpu_addr = 32'h0000_0500;
    exp_base     = 32'h0000_0500;
    last   = -1;
    npulse = 0;
    for (int c = 1; c <= 60 && npulse < 4; c++) begin
      @(negedge clock);
      if (bif.bus_valid && (c == last + 2)) check("hold_base", 64'(bif.bus_addr), 64'(exp_base));
      bif.bus_ready = bif.bus_valid;
      bif.bus_rdata = 16'(c);
      #1;
      if (bif.cpu_done) begin
        if (npulse == 0) check("hold_first", 64'(c), 64'(NB + 1));
        else check("hold_space", 64'(c - last), 64'(NB + 2));
        last   = c;
        npulse++;
        bif.cpu_addr = bif.cpu_addr + 32'h100;
        exp_base     = exp_base + 32'h100;
        if (npulse == 4) bif.cpu_req = 1'b0;
      end
    end
    check("hold_pulses", 64'(npulse), 64'd4);
    @(negedge clock);
    bif.bus_ready = 1'b0;
    #1;
    check("hold_idle", 64'(bif.cpu_stall), 64'd0);
    model_rdata = bif.cpu_rdata;

    // random traffic against the reference model
    for (int i = 0; i < 40; i++) do_access(make_random(), 1'b1);

`ifdef LEGV8_BUS_TIMEOUT_EN
    // stuck bus on a read: aborted after 4 wait cycles with an error
    @(negedge clock);
    bif.cpu_req  = 1'b1;
    bif.cpu_we   = 1'b0;
    bif.cpu_addr = 32'h0000_0700;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      bif.cpu_req   = 1'b0;
      bif.bus_ready = 1'b0;
      #1;
      if (c < 5) begin
        check("to_valid", 64'(bif.bus_valid), 64'd1);
        check("to_nodone", 64'(bif.cpu_done), 64'd0);
      end else begin
        check("to_done", 64'(bif.cpu_done), 64'd1);
        check("to_err", 64'(bif.cpu_err), 64'd1);
        check("to_drop", 64'(bif.bus_valid), 64'd0);
      end
    end
    @(negedge clock);
    #1;
    check("to_rdata", bif.cpu_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
